// File: rtl/ysyx_22040038_regfile_mp.sv
// Multi-port integer register file: NUM_RD async reads, two write ports, optional
// write-to-read bypass, x0 hardwired zero, busy scoreboard and a sequential clear FSM.
module ysyx_22040038_regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           w0_en,
    input  logic [ADDR_WIDTH-1:0]          w0_addr,
    input  logic [DATA_WIDTH-1:0]          w0_data,
    input  logic                           w1_en,
    input  logic [ADDR_WIDTH-1:0]          w1_addr,
    input  logic [DATA_WIDTH-1:0]          w1_data,
    input  logic                           busy_set_en,
    input  logic [ADDR_WIDTH-1:0]          busy_set_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clrCnt_q, clrCnt_d;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   rf_q [DEPTH];

    logic running;
    logic w0Live;
    logic w1Live;
    logic bsLive;

    assign running = (state_q == RUN);
    assign ready   = running;

    // Writes and busy_set only count in RUN and never target x0.
    assign w0Live = running && w0_en && (w0_addr != '0);
    assign w1Live = running && w1_en && (w1_addr != '0);
    assign bsLive = running && busy_set_en && (busy_set_addr != '0);

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        if (state_q == CLEAR) begin
            clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
            if (clrCnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            busy_q   <= busy_d;
        end
    end

    // Assignment order gives busy_set priority over a same-cycle write clear.
    always_comb begin
        busy_d = busy_q;
        if (w0Live) begin
            busy_d[w0_addr] = 1'b0;
        end
        if (w1Live) begin
            busy_d[w1_addr] = 1'b0;
        end
        if (bsLive) begin
            busy_d[busy_set_addr] = 1'b1;
        end
    end

    // Storage has no reset; the CLEAR sweep zeroes it after every reset release.
    always_ff @(posedge clk) begin
        if (!running) begin
            rf_q[clrCnt_q] <= '0;
        end else if (rst_n) begin
            if (w0Live && !(w1Live && (w1_addr == w0_addr))) begin
                rf_q[w0_addr] <= w0_data;
            end
            if (w1Live) begin
                rf_q[w1_addr] <= w1_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit0;
        logic                  hit1;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;

        assign addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit0 = w0Live && (w0_addr == addr);
        assign hit1 = w1Live && (w1_addr == addr);

        // W1 beats W0 on forwarding, matching the write-collision rule.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (running && (addr != '0)) begin
                if ((BYPASS != 0) && hit1) begin
                    data = w1_data;
                end else if ((BYPASS != 0) && hit0) begin
                    data = w0_data;
                end else begin
                    data = rf_q[addr];
                end
                busy = busy_q[addr] && !((BYPASS != 0) && (hit0 || hit1));
            end
        end

        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[g]                          = busy;
    end

endmodule
